clock_div_ctrl: RTL
===================

# clock_div_ctrl

Programmable clock-divider controller: generates a divided clock OutClock and a matching one-cycle Tick enable from InClock, with a run/stop state machine, a finite burst mode, and a valid/ready configuration port. Ratio changes are shadowed and applied only on period boundaries, so OutClock never produces a runt pulse. It replaces free-running counter dividers wherever downstream logic needs the divided clock started, stopped or re-ratioed at run time.

## Interface
- bw_Count, 8: width of divide ratio and phase counter.
- bw_Burst, 8: width of burst-length field.
- DefDiv, 4: divide ratio used before any configuration is accepted.

- InClock  in  1  clock.
- Reset  in  1  reset, asynchronous, active-high.
- CfgValid  in  1  configuration offered.
- CfgReady  out  1  configuration can be accepted.
- CfgDiv  in  bw_Count  divide ratio D; values 0 and 1 are treated as 2.
- CfgBurst  in  bw_Burst  periods per run; 0 = continuous.
- Start  in  1  begin running (level-sampled, acted on in IDLE only).
- Stop  in  1  request stop at end of current period.
- OutClock  out  1  divided clock, registered.
- Tick  out  1  one-cycle pulse on the first cycle of each OutClock period.
- Busy  out  1  high in RUN and DRAIN.
- BurstDone  out  1  one-cycle pulse when a finite burst completes.

## Operation
- States: IDLE, RUN, DRAIN.
- Active registers: Div (D), Burst, Phase (0..D-1), PeriodCnt. Shadow registers: ShDiv, ShBurst, ShPend.
- Config handshake: transfer when CfgValid && CfgReady. CfgReady = !ShPend. In IDLE the transfer loads Div/Burst directly (ShPend stays 0). In RUN/DRAIN it loads the shadow and sets ShPend.
- Period boundary: the cycle with Phase == D-1. At the boundary, if ShPend, copy the shadow to Div/Burst, clear ShPend and reset PeriodCnt to 0.
- IDLE -> RUN on Start (and not Stop). Phase = 0 and PeriodCnt = 0 on entry.
- RUN -> DRAIN on Stop when not at a boundary.
- RUN -> IDLE at a boundary if Stop is asserted, or if Burst != 0 and PeriodCnt == Burst-1. The burst case also pulses BurstDone.
- DRAIN -> IDLE at the next boundary. BurstDone is not pulsed for a Stop-terminated run.
- OutClock level in a RUN/DRAIN cycle with phase p is (p < D>>1). So D=2 gives a 1/1 duty cycle and D=3 gives high 1, low 2.
- Tick = 1 when p == 0.
- In IDLE: OutClock = 0, Tick = 0.
- Phase wraps D-1 -> 0. PeriodCnt increments at each boundary and saturates at all-ones in continuous mode.

## Timing
- Reset values: OutClock 0, Tick 0, Busy 0, BurstDone 0, CfgReady 1, state IDLE, Div = max(DefDiv, 2), Burst 0, ShPend 0.
- Reset mid-run forces IDLE immediately. Any pending shadow config is discarded.
- Start latency: Start sampled in cycle n -> OutClock = 1, Tick = 1, Busy = 1 in cycle n+1.
- Stop latency: IDLE is reached in the cycle after the current period's boundary. OutClock = 0 and Busy = 0 in that cycle. Stop on the boundary cycle itself stops with no extra period.
- Start and Stop together in IDLE: stay in IDLE. Start in RUN/DRAIN is ignored.
- A config transfer on the boundary cycle itself: applies at the following boundary. CfgReady stays low until then.
- BurstDone is asserted in the first IDLE cycle after the burst's last boundary.
- All outputs are driven from flops; no combinational path from inputs to outputs except CfgReady (from ShPend, a flop).

## Structure
- Shared package: state encoding constants (IDLE, RUN, DRAIN) and the divide-ratio clamp function (D < 2 -> 2).
- One natural sub-module, clock_div_phase: Phase counter plus OutClock/Tick generation from Div, with a boundary output. The FSM and config shadowing stay in the top.

## Test plan
- Reset, DefDiv=4, Start pulse -> OutClock pattern 1,1,0,0 repeating; Tick on every 4th cycle starting the cycle after Start.
- Configure D=3, Burst=2 in IDLE, then Start -> exactly 6 cycles of OutClock 1,0,0,1,0,0; then IDLE, with BurstDone in cycle 7.
- Running at D=4, write D=6 mid-period -> CfgReady low until the boundary; the next period is 1,1,1,0,0,0 with no runt pulse.
- Running at D=8, Stop at phase 2 -> DRAIN through phase 7; IDLE at the next cycle; no BurstDone.
- CfgDiv=0 or 1 -> behaves as D=2 (1,0 toggling).
- Assert Reset at phase 3 of a burst with a pending config -> all outputs at reset values next cycle; after Start the old Div is used and the pending config is gone.

Source files
------------

// File: rtl/clock_div_ctrl_pkg.sv
// Shared definitions for the programmable clock divider: controller state
// encoding and the divide-ratio clamp.
package clock_div_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } ctrlState_t;

  // Ratios below 2 cannot form a high and a low phase, so they run as 2.
  function automatic int unsigned clampDiv(input int unsigned d);
    return (d < 2) ? 2 : d;
  endfunction

endpackage

// File: rtl/clock_div_phase.sv
// Phase counter for one divided-clock period plus registered OutClock/Tick.
// Outputs are computed from the next-cycle phase so they line up with Phase.
module clock_div_phase #(
  parameter int unsigned bw_Count = 8
) (
  input  logic                InClock,
  input  logic                Reset,
  input  logic                Active,
  input  logic                NextActive,
  input  logic [bw_Count-1:0] Div,
  input  logic [bw_Count-1:0] NextDiv,
  output logic                Boundary,
  output logic                OutClock,
  output logic                Tick
);

  logic [bw_Count-1:0] phase;
  logic [bw_Count-1:0] nextPhase;

  assign Boundary = Active && (phase == Div - bw_Count'(1));

  // A fresh run or a wrap restarts at phase 0.
  always_comb begin
    nextPhase = '0;
    if (NextActive && Active && !Boundary)
      nextPhase = phase + bw_Count'(1);
  end

  always_ff @(posedge InClock or posedge Reset) begin
    if (Reset) begin
      phase    <= '0;
      OutClock <= 1'b0;
      Tick     <= 1'b0;
    end else begin
      phase    <= nextPhase;
      OutClock <= NextActive && (nextPhase < (NextDiv >> 1));
      Tick     <= NextActive && (nextPhase == '0);
    end
  end

endmodule

// File: rtl/clock_div_ctrl.sv
// Run/stop/burst controller for a programmable clock divider. Ratio and burst
// updates made while running are held in a shadow until a period boundary.
module clock_div_ctrl
  import clock_div_ctrl_pkg::*;
#(
  parameter int unsigned bw_Count = 8,
  parameter int unsigned bw_Burst = 8,
  parameter int unsigned DefDiv   = 4
) (
  input  logic                InClock,
  input  logic                Reset,
  input  logic                CfgValid,
  output logic                CfgReady,
  input  logic [bw_Count-1:0] CfgDiv,
  input  logic [bw_Burst-1:0] CfgBurst,
  input  logic                Start,
  input  logic                Stop,
  output logic                OutClock,
  output logic                Tick,
  output logic                Busy,
  output logic                BurstDone
);

  localparam logic [bw_Count-1:0] ResetDiv = bw_Count'(clampDiv(DefDiv));

  ctrlState_t          state;
  logic [bw_Count-1:0] div;
  logic [bw_Count-1:0] nextDiv;
  logic [bw_Burst-1:0] burst;
  logic [bw_Burst-1:0] periodCnt;
  logic [bw_Count-1:0] shDiv;
  logic [bw_Burst-1:0] shBurst;
  logic                shPend;

  logic                cfgFire;
  logic [bw_Count-1:0] cfgDivClamped;
  logic                boundary;
  logic                isIdle;
  logic                goRun;
  logic                burstEnd;
  logic                endRun;
  logic                nextActive;

  assign CfgReady      = !shPend;
  assign cfgFire       = CfgValid && CfgReady;
  assign cfgDivClamped = bw_Count'(clampDiv(32'(CfgDiv)));
  assign isIdle        = (state == StIdle);
  assign goRun         = isIdle && Start && !Stop;
  assign burstEnd      = boundary && (state == StRun) && (burst != '0) &&
                         (periodCnt == burst - bw_Burst'(1));
  assign endRun        = boundary && ((state == StDrain) ||
                                      ((state == StRun) && (Stop || burstEnd)));
  assign nextActive    = goRun || (!isIdle && !endRun);

  // Ratio in force next cycle; the phase block needs it to pre-compute outputs.
  always_comb begin
    nextDiv = div;
    if (isIdle) begin
      if (cfgFire)
        nextDiv = cfgDivClamped;
      else if (shPend)
        nextDiv = shDiv;
    end else if (boundary && shPend) begin
      nextDiv = shDiv;
    end
  end

  always_ff @(posedge InClock or posedge Reset) begin
    if (Reset) begin
      state     <= StIdle;
      div       <= ResetDiv;
      burst     <= '0;
      periodCnt <= '0;
      shDiv     <= '0;
      shBurst   <= '0;
      shPend    <= 1'b0;
      Busy      <= 1'b0;
      BurstDone <= 1'b0;
    end else begin
      div       <= nextDiv;
      Busy      <= nextActive;
      BurstDone <= burstEnd;
      case (state)
        StIdle: begin
          // A shadow left over from a run that just ended is applied here.
          if (cfgFire) begin
            burst <= CfgBurst;
          end else if (shPend) begin
            burst  <= shBurst;
            shPend <= 1'b0;
          end
          if (goRun) begin
            state     <= StRun;
            periodCnt <= '0;
          end
        end
        StRun, StDrain: begin
          if (cfgFire) begin
            shDiv   <= cfgDivClamped;
            shBurst <= CfgBurst;
            shPend  <= 1'b1;
          end
          if (boundary) begin
            if (shPend) begin
              burst     <= shBurst;
              shPend    <= 1'b0;
              periodCnt <= '0;
            end else if (periodCnt != '1) begin
              periodCnt <= periodCnt + bw_Burst'(1);
            end
          end
          if (endRun)
            state <= StIdle;
          else if ((state == StRun) && Stop && !boundary)
            state <= StDrain;
        end
        default: state <= StIdle;
      endcase
    end
  end

  clock_div_phase #(
    .bw_Count(bw_Count)
  ) uPhase (
    .InClock   (InClock),
    .Reset     (Reset),
    .Active    (!isIdle),
    .NextActive(nextActive),
    .Div       (div),
    .NextDiv   (nextDiv),
    .Boundary  (boundary),
    .OutClock  (OutClock),
    .Tick      (Tick)
  );

endmodule
